// File: rtl/cdc_tx_pkg.sv
// rtl/cdc_tx_pkg.sv - shared types and limits for the toggle req/ack CDC launch side
package cdc_tx_pkg;

  typedef enum logic {
    CDC_TX_IDLE     = 1'b0,
    CDC_TX_WAIT_ACK = 1'b1
  } cdc_tx_state_e;

  localparam int CDC_SYNC_MIN = 2;
  localparam int CDC_SYNC_MAX = 3;

  // Out-of-range depths are pinned to the nearest legal value.
  function automatic int cdc_sync_depth(input int stages);
    if (stages < CDC_SYNC_MIN) return CDC_SYNC_MIN;
    if (stages > CDC_SYNC_MAX) return CDC_SYNC_MAX;
    return stages;
  endfunction

endpackage

// File: rtl/sync_ff_rst.sv
// rtl/sync_ff_rst.sv - STAGES-deep single-bit synchronizer with async active-low reset
module sync_ff_rst #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_tx_handshake.sv
// rtl/cdc_tx_handshake.sv - source-side launcher for a two-phase req/ack crossing
// Optional one-word holding buffer enabled by CDC_TX_SKID_EN.
module cdc_tx_handshake
  import cdc_tx_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_req,
  input  logic             tx_ack,
  output logic             busy,
  output logic             proto_err
);

  localparam int SyncDepth = cdc_sync_depth(SYNC_STAGES);

  cdc_tx_state_e    state_q, state_d;
  logic             tx_req_q, tx_req_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             ack_s, ack_s_q;
  logic             proto_err_q, proto_err_d;
  logic             accept;
  logic             done;

  sync_ff_rst #(
    .STAGES(SyncDepth)
  ) u_ack_sync (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (tx_ack),
    .q_o   (ack_s)
  );

`ifdef CDC_TX_SKID_EN
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  assign in_ready = !skid_vld_q;
`else
  assign in_ready = (state_q == CDC_TX_IDLE);
`endif

  assign accept = in_valid && in_ready;
  assign done   = (state_q == CDC_TX_WAIT_ACK) && (ack_s == tx_req_q);

  always_comb begin
    state_d     = state_q;
    tx_req_d    = tx_req_q;
    tx_data_d   = tx_data_q;
    proto_err_d = proto_err_q;
`ifdef CDC_TX_SKID_EN
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
`endif

    // Nothing is outstanding in IDLE, so any ack edge is spurious.
    if ((state_q == CDC_TX_IDLE) && (ack_s != ack_s_q)) begin
      proto_err_d = 1'b1;
    end

    case (state_q)
      CDC_TX_IDLE: begin
        if (accept) begin
          tx_data_d = in_data;
          tx_req_d  = ~tx_req_q;
          state_d   = CDC_TX_WAIT_ACK;
        end
      end
      CDC_TX_WAIT_ACK: begin
`ifdef CDC_TX_SKID_EN
        if (done && skid_vld_q) begin
          tx_data_d  = skid_data_q;
          tx_req_d   = ~tx_req_q;
          skid_vld_d = 1'b0;
        end else if (done && accept) begin
          // Buffer is empty, so the fresh word goes straight out.
          tx_data_d = in_data;
          tx_req_d  = ~tx_req_q;
        end else if (done) begin
          state_d = CDC_TX_IDLE;
        end else if (accept) begin
          skid_vld_d  = 1'b1;
          skid_data_d = in_data;
        end
`else
        if (done) begin
          state_d = CDC_TX_IDLE;
        end
`endif
      end
      default: state_d = CDC_TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CDC_TX_IDLE;
      tx_req_q    <= 1'b0;
      tx_data_q   <= '0;
      ack_s_q     <= 1'b0;
      proto_err_q <= 1'b0;
`ifdef CDC_TX_SKID_EN
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tx_req_q    <= tx_req_d;
      tx_data_q   <= tx_data_d;
      ack_s_q     <= ack_s;
      proto_err_q <= proto_err_d;
`ifdef CDC_TX_SKID_EN
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
`endif
    end
  end

  assign tx_req    = tx_req_q;
  assign tx_data   = tx_data_q;
  assign busy      = (state_q == CDC_TX_WAIT_ACK);
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cdc_tx_handshake.sv
// tb/tb_cdc_tx_handshake.sv - self-checking bench for cdc_tx_handshake
module tb_cdc_tx_handshake;

  localparam int W = 16;
  localparam int S = 2;
`ifdef CDC_TX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [W-1:0] tx_data;
  logic         tx_req;
  logic         tx_ack;
  logic         busy;
  logic         proto_err;

  logic ack_man, lb_en, lb1, lb2;
  int   n_chk = 0;
  int   n_err = 0;

  logic [W-1:0] sb[$];
  logic [W-1:0] rx[$];
  logic         last_req;
  logic [W-1:0] last_data;
  int           stab_bad;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         ack;
    logic         ready;
    logic         bsy;
    logic         req;
    logic [W-1:0] data;
    logic         perr;
  } vec_t;

  vec_t tbl[14];

  always #5 clk = ~clk;

  assign tx_ack = lb_en ? lb2 : ack_man;

  cdc_tx_handshake #(
    .WIDTH      (W),
    .SYNC_STAGES(S)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .tx_ack   (tx_ack),
    .busy     (busy),
    .proto_err(proto_err)
  );

  // Destination stand-in: acks by echoing tx_req two clk edges later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lb1 <= 1'b0;
      lb2 <= 1'b0;
    end else begin
      lb1 <= tx_req;
      lb2 <= lb1;
    end
  end

  always @(posedge clk) begin
    if (!reset_n) sb.delete();
    else if (in_valid && in_ready) sb.push_back(in_data);
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      last_req  = 1'b0;
      last_data = '0;
      stab_bad  = 0;
      rx.delete();
    end else if (tx_req !== last_req) begin
      last_req  = tx_req;
      last_data = tx_data;
      rx.push_back(tx_data);
    end else if (busy && (tx_data !== last_data)) begin
      stab_bad++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset(input bit lb);
    in_valid = 1'b0;
    in_data  = '0;
    ack_man  = 1'b0;
    reset_n  = 1'b0;
    lb_en    = lb;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_drain(input string nm);
    int g;
    g = 0;
    in_valid = 1'b0;
    while (!(in_ready && !busy) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk(nm, 32'(g < 200), 32'd1);
  endtask

  task automatic cmp_stream(input string nm);
    chk({nm, "_count"}, 32'(rx.size()), 32'(sb.size()));
    for (int i = 0; i < sb.size() && i < rx.size(); i++)
      chk($sformatf("%s_word%0d", nm, i), 32'(rx[i]), 32'(sb[i]));
    chk({nm, "_stable"}, 32'(stab_bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic m_busy, m_req, fire, done;
    logic hist[$];
    int   cnt;

    //          v  d         ack ready busy req data      perr
    tbl[0]  = '{1, 16'hA5A5, 0,  0,    1,   1,  16'hA5A5, 0};
    tbl[1]  = '{0, 16'h0000, 0,  0,    1,   1,  16'hA5A5, 0};
    tbl[2]  = '{0, 16'h0000, 1,  0,    1,   1,  16'hA5A5, 0};
    tbl[3]  = '{0, 16'h0000, 1,  0,    1,   1,  16'hA5A5, 0};
    tbl[4]  = '{0, 16'h0000, 1,  1,    0,   1,  16'hA5A5, 0};
    tbl[5]  = '{1, 16'h1234, 1,  0,    1,   0,  16'h1234, 0};
    tbl[6]  = '{0, 16'h0000, 0,  0,    1,   0,  16'h1234, 0};
    tbl[7]  = '{0, 16'h0000, 0,  0,    1,   0,  16'h1234, 0};
    tbl[8]  = '{0, 16'h0000, 0,  1,    0,   0,  16'h1234, 0};
    tbl[9]  = '{0, 16'h0000, 1,  1,    0,   0,  16'h1234, 0};
    tbl[10] = '{0, 16'h0000, 1,  1,    0,   0,  16'h1234, 0};
    tbl[11] = '{0, 16'h0000, 1,  1,    0,   0,  16'h1234, 1};
    tbl[12] = '{1, 16'h00FF, 1,  0,    1,   1,  16'h00FF, 1};
    tbl[13] = '{0, 16'h0000, 1,  1,    0,   1,  16'h00FF, 1};

    in_valid = 1'b0;
    in_data  = '0;
    ack_man  = 1'b0;
    lb_en    = 1'b0;
    reset_n  = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);

    // Cycle-by-cycle vectors: manual ack, spurious toggle in IDLE
    do_reset(1'b0);
    for (int i = 0; i < 14; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      ack_man  = tbl[i].ack;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), SKID ? 32'd1 : 32'(tbl[i].ready));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("vec%0d_req", i), 32'(tx_req), 32'(tbl[i].req));
      chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(tbl[i].data));
      chk($sformatf("vec%0d_perr", i), 32'(proto_err), 32'(tbl[i].perr));
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("perr_sticky", 32'(proto_err), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("perr_cleared_by_reset", 32'(proto_err), 32'd0);

    // Single word with loopback ack
    do_reset(1'b1);
    in_valid = 1'b1;
    in_data  = 16'hA5A5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("single_req", 32'(tx_req), 32'd1);
    chk("single_data", 32'(tx_data), 32'hA5A5);
    cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    chk("single_busy_cycles", 32'(cnt), 32'(S + 3));
    chk("single_ready_back", 32'(in_ready), 32'd1);

    // Back-to-back producer
    do_reset(1'b1);
    for (int i = 1; i <= 4; i++) begin
      int g;
      g = 0;
      in_valid = 1'b1;
      in_data  = W'(i);
      while (!in_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      chk("b2b_accept_wait", 32'(g < 100), 32'd1);
      @(negedge clk);
    end
    wait_drain("b2b_drain");
    cmp_stream("b2b");

    // Ack stall: nothing moves for 100 cycles
    do_reset(1'b0);
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_ready", 32'(in_ready), SKID ? 32'd1 : 32'd0);
      chk("stall_data", 32'(tx_data), 32'hBEEF);
    end
    ack_man = 1'b1;
    wait_drain("stall_release");
    chk("stall_no_err", 32'(proto_err), 32'd0);

    // Reset in WAIT_ACK acts without a clock edge
    do_reset(1'b0);
    in_valid = 1'b1;
    in_data  = 16'h7E57;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    chk("midrst_pre_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_req", 32'(tx_req), 32'd0);
    chk("midrst_data", 32'(tx_data), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);

`ifdef CDC_TX_SKID_EN
    // Holding buffer: second word taken while the first is in flight
    do_reset(1'b0);
    in_valid = 1'b1;
    in_data  = 16'h1111;
    chk("skid_w1_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_data = 16'h2222;
    chk("skid_w2_ready", 32'(in_ready), 32'd1);
    chk("skid_w1_out", 32'(tx_data), 32'h1111);
    @(negedge clk);
    in_data = 16'h3333;
    chk("skid_w3_blocked", 32'(in_ready), 32'd0);
    chk("skid_w1_held", 32'(tx_data), 32'h1111);
    ack_man = 1'b1;
    cnt = 0;
    while (tx_req == 1'b1 && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    in_valid = 1'b0;
    chk("skid_launch_seen", 32'(cnt < 50), 32'd1);
    chk("skid_w2_out", 32'(tx_data), 32'h2222);
    chk("skid_busy_kept", 32'(busy), 32'd1);
    chk("skid_ready_after", 32'(in_ready), 32'd1);
`endif

    // Randomised traffic against a cycle-level reference model
    do_reset(1'b1);
    m_busy = 1'b0;
    m_req  = 1'b0;
    hist.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!SKID) chk("rand_ready", 32'(in_ready), 32'(!m_busy));
      hist.push_back(tx_ack);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      fire = in_valid && !m_busy;
      // Completion: the ack level sampled S edges back matches the live request.
      done = m_busy && (hist.size() > S) && (hist[hist.size() - 1 - S] == m_req);
      @(posedge clk);
      if (fire) begin
        m_req  = !m_req;
        m_busy = 1'b1;
      end else if (done) begin
        m_busy = 1'b0;
      end
    end
    wait_drain("rand_drain");
    cmp_stream("rand");
    chk("rand_no_err", 32'(proto_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
